// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution sequencer: opcodes, FSM states, default widths.
package alu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;
    localparam logic [3:0] OP_MOV = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RDA  = 3'd1,
        ST_RDB  = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: (op, A, B) -> result, zero/carry/overflow flags, illegal-op indication.
// Build option ALU_MUL_EN adds op 11 (unsigned multiply, low half); otherwise op 11 is illegal.
module alu_core #(
    parameter int DATA_W = alu_pkg::DEF_DATA_W
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_o,
    output logic              z_o,
    output logic              c_o,
    output logic              v_o,
    output logic              illegal_o
);
    import alu_pkg::*;

    logic [DATA_W:0] add_w;
    logic [DATA_W:0] sub_w;
    logic [4:0]      shamt;
`ifdef ALU_MUL_EN
    logic [2*DATA_W-1:0] prod_w;
`endif

    always_comb begin
        res_o     = '0;
        c_o       = 1'b0;
        v_o       = 1'b0;
        illegal_o = 1'b0;
        add_w     = {1'b0, a_i} + {1'b0, b_i};
        sub_w     = {1'b0, a_i} - {1'b0, b_i};
        shamt     = b_i[4:0];
`ifdef ALU_MUL_EN
        prod_w    = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
`endif
        case (op_i)
            OP_NOP: res_o = '0;
            OP_ADD: begin
                res_o = add_w[DATA_W-1:0];
                c_o   = add_w[DATA_W];
                v_o   = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (res_o[DATA_W-1] != a_i[DATA_W-1]);
            end
            // Bit DATA_W of the widened difference is the borrow (A < B unsigned).
            OP_SUB: begin
                res_o = sub_w[DATA_W-1:0];
                c_o   = sub_w[DATA_W];
                v_o   = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (res_o[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_NOT: res_o = ~a_i;
            OP_SHL: res_o = a_i << shamt;
            OP_LSR: res_o = a_i >> shamt;
            OP_ASR: res_o = $unsigned($signed(a_i) >>> shamt);
            OP_MOV: res_o = a_i;
`ifdef ALU_MUL_EN
            OP_MUL: begin
                res_o = prod_w[DATA_W-1:0];
                c_o   = |prod_w[2*DATA_W-1:DATA_W];
            end
`endif
            default: illegal_o = 1'b1;
        endcase
    end

    assign z_o = (res_o == '0);

endmodule

// File: rtl/alu_exec_sequencer.sv
// Command sequencer: reads A and B through the single register-file read port, executes, writes back.
// Multiply support is selected with ALU_MUL_EN (see alu_core).
module alu_exec_sequencer #(
    parameter int DATA_W = alu_pkg::DEF_DATA_W,
    parameter int ADDR_W = alu_pkg::DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_srcA,
    input  logic [ADDR_W-1:0] cmd_srcB,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic [ADDR_W-1:0] rAddr,
    input  logic [DATA_W-1:0] rData,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wData,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic              done,
    output logic              err
);
    import alu_pkg::*;

    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] srca_q, srcb_q, dst_q;
    logic [DATA_W-1:0] opa_q, opb_q, result_q;
    logic              z_q, c_q, v_q;

    logic [DATA_W-1:0] core_res;
    logic              core_z, core_c, core_v, core_illegal;

    alu_core #(.DATA_W(DATA_W)) u_core (
        .op_i      (op_q),
        .a_i       (opa_q),
        .b_i       (opb_q),
        .res_o     (core_res),
        .z_o       (core_z),
        .c_o       (core_c),
        .v_o       (core_v),
        .illegal_o (core_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Port drive is decoded from state so an async reset clears it immediately.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rAddr     = '0;
        we        = 1'b0;
        wAddr     = '0;
        wData     = '0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = ST_RDA;
            end
            ST_RDA: begin
                rAddr   = srca_q;
                state_d = ST_RDB;
            end
            ST_RDB: begin
                rAddr   = srcb_q;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (core_illegal) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                done    = 1'b1;
                state_d = ST_IDLE;
                if (op_q != OP_NOP) begin
                    we    = 1'b1;
                    wAddr = dst_q;
                    wData = result_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= OP_NOP;
            srca_q   <= '0;
            srcb_q   <= '0;
            dst_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && cmd_valid) begin
                op_q   <= cmd_op;
                srca_q <= cmd_srcA;
                srcb_q <= cmd_srcB;
                dst_q  <= cmd_dst;
            end
            if (state_q == ST_RDA) opa_q <= rData;
            if (state_q == ST_RDB) opb_q <= rData;
            // NOP computes nothing, so it leaves the previous result and flags in place.
            if (state_q == ST_EXEC && !core_illegal && op_q != OP_NOP) begin
                result_q <= core_res;
                z_q      <= core_z;
                c_q      <= core_c;
                v_q      <= core_v;
            end
        end
    end

    assign result = result_q;
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign flag_v = v_q;

endmodule
